// File: rtl/exc_ctrl_if.sv
// Commit-stage bus between writeback and the exception controller.
// The writeback side offers one instruction; the controller accepts it.
interface exc_ctrl_if;
  logic        cmt_valid;
  logic        cmt_ready;
  logic [31:0] cmt_pc;
  logic [3:0]  f_exc;
  logic [3:0]  d_exc;
  logic [5:0]  m_exc;
  logic [31:0] m_vaddr;
  logic        op_ertn;
  logic        op_idle;
  logic        op_refetch;

  modport master (
    output cmt_valid,
    output cmt_pc,
    output f_exc,
    output d_exc,
    output m_exc,
    output m_vaddr,
    output op_ertn,
    output op_idle,
    output op_refetch,
    input  cmt_ready
  );

  modport slave (
    input  cmt_valid,
    input  cmt_pc,
    input  f_exc,
    input  d_exc,
    input  m_exc,
    input  m_vaddr,
    input  op_ertn,
    input  op_idle,
    input  op_refetch,
    output cmt_ready
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt commit controller: prioritises events,
// pulses them to the CSR file and stalls commit while redirecting.
module exc_ctrl #(
  parameter int REDIRECT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  exc_ctrl_if.slave   cmt,
  input  logic [11:0] is,
  input  logic [11:0] lie,
  input  logic        ie,
  output logic        is_exc,
  output logic [5:0]  excode,
  output logic [8:0]  esubcode,
  output logic [31:0] badvaddr,
  output logic [31:0] csr_pc,
  output logic        is_ertn,
  output logic        is_idle,
  output logic        is_fetch_again,
  output logic        flush
);

  localparam int CW =
    (REDIRECT_CYC < 1) ? 1 : $clog2(REDIRECT_CYC + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(REDIRECT_CYC);

  localparam logic [5:0] EC_INT  = 6'h00;
  localparam logic [5:0] EC_PIL  = 6'h01;
  localparam logic [5:0] EC_PIS  = 6'h02;
  localparam logic [5:0] EC_PIF  = 6'h03;
  localparam logic [5:0] EC_PME  = 6'h04;
  localparam logic [5:0] EC_PPI  = 6'h07;
  localparam logic [5:0] EC_ADEF = 6'h08;
  localparam logic [5:0] EC_ALE  = 6'h09;
  localparam logic [5:0] EC_SYS  = 6'h0B;
  localparam logic [5:0] EC_BRK  = 6'h0C;
  localparam logic [5:0] EC_INE  = 6'h0D;
  localparam logic [5:0] EC_IPE  = 6'h0E;
  localparam logic [5:0] EC_TLBR = 6'h3F;

  typedef enum logic [1:0] {
    S_RUN,
    S_REDIR,
    S_IDLE
  } state_t;

  state_t      r_state;
  state_t      w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;

  logic        r_is_exc;
  logic        r_is_ertn;
  logic        r_is_fa;
  logic        r_is_idle;
  logic        r_flush;
  logic [5:0]  r_excode;
  logic [31:0] r_badvaddr;
  logic [31:0] r_csr_pc;

  logic        w_n_exc;
  logic        w_n_ertn;
  logic        w_n_fa;
  logic        w_n_idle;
  logic        w_n_flush;
  logic [5:0]  w_n_code;
  logic [31:0] w_n_bad;
  logic [31:0] w_n_pc;

  logic        w_int_p;
  logic        w_hs;
  logic        w_d_exc;
  logic        w_d_ertn;
  logic        w_d_rf;
  logic        w_d_idle;
  logic        w_d_bad_pc;
  logic        w_d_bad_va;
  logic [5:0]  w_d_code;
  logic        w_d_redir;
  logic        w_d_any;

  assign w_int_p = ie & (|(is & lie));
  assign cmt.cmt_ready = (r_state == S_RUN) & ~reset;
  assign w_hs = cmt.cmt_valid & cmt.cmt_ready;

  // Bit order: f {ppi,pif,tlbr,adef}, d {ipe,ine,brk,sys},
  // m {ppi,pme,pis,pil,tlbr,ale}; bit 0 is highest priority.
  always_comb begin
    w_d_exc    = 1'b0;
    w_d_ertn   = 1'b0;
    w_d_rf     = 1'b0;
    w_d_idle   = 1'b0;
    w_d_bad_pc = 1'b0;
    w_d_bad_va = 1'b0;
    w_d_code   = EC_INT;
    priority case (1'b1)
      w_int_p: begin
        w_d_exc  = 1'b1;
        w_d_code = EC_INT;
      end
      cmt.f_exc[0]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_ADEF;
        w_d_bad_pc = 1'b1;
      end
      cmt.f_exc[1]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_TLBR;
        w_d_bad_pc = 1'b1;
      end
      cmt.f_exc[2]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_PIF;
        w_d_bad_pc = 1'b1;
      end
      cmt.f_exc[3]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_PPI;
        w_d_bad_pc = 1'b1;
      end
      cmt.d_exc[0]: begin
        w_d_exc  = 1'b1;
        w_d_code = EC_SYS;
      end
      cmt.d_exc[1]: begin
        w_d_exc  = 1'b1;
        w_d_code = EC_BRK;
      end
      cmt.d_exc[2]: begin
        w_d_exc  = 1'b1;
        w_d_code = EC_INE;
      end
      cmt.d_exc[3]: begin
        w_d_exc  = 1'b1;
        w_d_code = EC_IPE;
      end
      cmt.m_exc[0]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_ALE;
        w_d_bad_va = 1'b1;
      end
      cmt.m_exc[1]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_TLBR;
        w_d_bad_va = 1'b1;
      end
      cmt.m_exc[2]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_PIL;
        w_d_bad_va = 1'b1;
      end
      cmt.m_exc[3]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_PIS;
        w_d_bad_va = 1'b1;
      end
      cmt.m_exc[4]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_PME;
        w_d_bad_va = 1'b1;
      end
      cmt.m_exc[5]: begin
        w_d_exc    = 1'b1;
        w_d_code   = EC_PPI;
        w_d_bad_va = 1'b1;
      end
      cmt.op_ertn:    w_d_ertn = 1'b1;
      cmt.op_refetch: w_d_rf   = 1'b1;
      cmt.op_idle:    w_d_idle = 1'b1;
      default: ;
    endcase
  end

  assign w_d_redir = w_d_exc | w_d_ertn | w_d_rf;
  assign w_d_any   = w_d_redir | w_d_idle;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_n_exc  = 1'b0;
    w_n_ertn = 1'b0;
    w_n_fa   = 1'b0;
    w_n_idle = 1'b0;
    w_n_code = r_excode;
    w_n_bad  = r_badvaddr;
    w_n_pc   = r_csr_pc;
    case (r_state)
      S_RUN: begin
        if (w_hs) begin
          if (w_d_redir) begin
            w_nstate = S_REDIR;
            w_ncnt   = C_LOAD;
          end else if (w_d_idle) begin
            w_nstate = S_IDLE;
          end
          w_n_exc  = w_d_exc;
          w_n_ertn = w_d_ertn;
          w_n_fa   = w_d_rf;
          w_n_idle = w_d_idle;
          if (w_d_any) w_n_pc = cmt.cmt_pc;
          if (w_d_exc) w_n_code = w_d_code;
          if (w_d_bad_pc) w_n_bad = cmt.cmt_pc;
          if (w_d_bad_va) w_n_bad = cmt.m_vaddr;
        end
      end
      S_REDIR: begin
        if (r_cnt == '0) w_nstate = S_RUN;
        else w_ncnt = r_cnt - CW'(1);
      end
      S_IDLE: begin
        // Wake-up keeps csr_pc at the idle instruction.
        if (w_int_p) begin
          w_nstate = S_REDIR;
          w_ncnt   = C_LOAD;
          w_n_exc  = 1'b1;
          w_n_code = EC_INT;
        end
      end
      default: w_nstate = S_RUN;
    endcase
  end

  assign w_n_flush = w_n_exc | w_n_ertn | w_n_fa | w_n_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_is_exc   <= 1'b0;
      r_is_ertn  <= 1'b0;
      r_is_fa    <= 1'b0;
      r_is_idle  <= 1'b0;
      r_flush    <= 1'b0;
      r_excode   <= '0;
      r_badvaddr <= '0;
      r_csr_pc   <= '0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_ncnt;
      r_is_exc   <= w_n_exc;
      r_is_ertn  <= w_n_ertn;
      r_is_fa    <= w_n_fa;
      r_is_idle  <= w_n_idle;
      r_flush    <= w_n_flush;
      r_excode   <= w_n_code;
      r_badvaddr <= w_n_bad;
      r_csr_pc   <= w_n_pc;
    end
  end

  assign is_exc         = r_is_exc;
  assign is_ertn        = r_is_ertn;
  assign is_fetch_again = r_is_fa;
  assign is_idle        = r_is_idle;
  assign flush          = r_flush;
  assign excode         = r_excode;
  assign esubcode       = 9'd0;
  assign badvaddr       = r_badvaddr;
  assign csr_pc         = r_csr_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with an expected-event queue.
// Inputs change on the falling edge; outputs are checked there too.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] is;
  logic [11:0] lie;
  logic        ie;
  logic        is_exc;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr;
  logic [31:0] csr_pc;
  logic        is_ertn;
  logic        is_idle;
  logic        is_fetch_again;
  logic        flush;

  exc_ctrl_if bus();

  exc_ctrl #(.REDIRECT_CYC(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmt            (bus),
    .is             (is),
    .lie            (lie),
    .ie             (ie),
    .is_exc         (is_exc),
    .excode         (excode),
    .esubcode       (esubcode),
    .badvaddr       (badvaddr),
    .csr_pc         (csr_pc),
    .is_ertn        (is_ertn),
    .is_idle        (is_idle),
    .is_fetch_again (is_fetch_again),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic        ertn;
    logic        fa;
    logic        idl;
    logic [5:0]  code;
    logic [31:0] bad;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic exc, input logic ertn,
                           input logic fa, input logic idl,
                           input logic [5:0] code,
                           input logic [31:0] bad,
                           input logic [31:0] pc);
    exp_t e;
    e.exc = exc; e.ertn = ertn; e.fa = fa; e.idl = idl;
    e.code = code; e.bad = bad; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic check_pulse(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_is_exc"}, is_exc, e.exc);
    chk({tag, "_is_ertn"}, is_ertn, e.ertn);
    chk({tag, "_is_fa"}, is_fetch_again, e.fa);
    chk({tag, "_is_idle"}, is_idle, e.idl);
    chk({tag, "_flush"}, flush, e.exc | e.ertn | e.fa | e.idl);
    chk({tag, "_esub"}, esubcode, 0);
    chk({tag, "_badv"}, badvaddr, e.bad);
    chk({tag, "_pc"}, csr_pc, e.pc);
    if (e.exc) chk({tag, "_code"}, excode, e.code);
  endtask

  task automatic quiet(input string tag);
    chk(tag, {is_exc, is_ertn, is_fetch_again, is_idle, flush}, 0);
  endtask

  task automatic clr_bus();
    bus.cmt_valid  = 1'b0;
    bus.cmt_pc     = '0;
    bus.f_exc      = '0;
    bus.d_exc      = '0;
    bus.m_exc      = '0;
    bus.m_vaddr    = '0;
    bus.op_ertn    = 1'b0;
    bus.op_idle    = 1'b0;
    bus.op_refetch = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge of the
  // cycle after the handshake (the pulse cycle).
  task automatic commit(input logic [31:0] pc,
                        input logic [3:0] f, input logic [3:0] d,
                        input logic [5:0] m, input logic [31:0] va,
                        input logic ertn, input logic idl,
                        input logic rf);
    int k;
    bus.cmt_valid  = 1'b1;
    bus.cmt_pc     = pc;
    bus.f_exc      = f;
    bus.d_exc      = d;
    bus.m_exc      = m;
    bus.m_vaddr    = va;
    bus.op_ertn    = ertn;
    bus.op_idle    = idl;
    bus.op_refetch = rf;
    k = 0;
    while (bus.cmt_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rdy_wait", bus.cmt_ready, 1);
    @(posedge clk);
    #1 clr_bus();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    is = '0; lie = '0; ie = 1'b0;
    clr_bus();
    repeat (2) @(negedge clk);
    chk("rst_rdy", bus.cmt_ready, 0);
    quiet("rst_pulses");
    chk("rst_code", excode, 0);
    chk("rst_badv", badvaddr, 0);
    chk("rst_pc", csr_pc, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("run_rdy", bus.cmt_ready, 1);

    expect_ev(1, 0, 0, 0, 6'h09, 32'h12340003, 32'h1c000100);
    commit(32'h1c000100, 0, 0, 6'b000001, 32'h12340003, 0, 0, 0);
    check_pulse("ale");
    chk("ale_rdy_c0", bus.cmt_ready, 0);
    @(negedge clk);
    quiet("ale_one_cycle");
    chk("ale_rdy_c1", bus.cmt_ready, 0);
    @(negedge clk);
    chk("ale_rdy_c2", bus.cmt_ready, 0);
    @(negedge clk);
    chk("ale_rdy_back", bus.cmt_ready, 1);

    expect_ev(1, 0, 0, 0, 6'h08, 32'h8, 32'h8);
    commit(32'h8, 4'b0101, 4'b0001, 0, 32'hdead0000, 0, 0, 0);
    check_pulse("adef");

    commit(32'h10, 0, 0, 0, 32'hdead0000, 0, 0, 0);
    quiet("clean");
    chk("clean_rdy", bus.cmt_ready, 1);
    chk("clean_code_hold", excode, 32'h08);
    chk("clean_pc_hold", csr_pc, 32'h8);

    is = 12'h004; lie = 12'h004; ie = 1'b1;
    expect_ev(1, 0, 0, 0, 6'h00, 32'h8, 32'h20);
    commit(32'h20, 0, 0, 0, 32'hffff0000, 0, 0, 0);
    check_pulse("int");
    ie = 1'b0;
    commit(32'h24, 0, 0, 0, 0, 0, 0, 0);
    quiet("int_masked");

    ie = 1'b1;
    expect_ev(1, 0, 0, 0, 6'h00, 32'h8, 32'h28);
    commit(32'h28, 4'b0001, 0, 0, 0, 0, 0, 0);
    check_pulse("int_over_f");
    ie = 1'b0;

    expect_ev(1, 0, 0, 0, 6'h3f, 32'h55550000, 32'h2c);
    commit(32'h2c, 0, 0, 6'b000110, 32'h55550000, 0, 0, 0);
    check_pulse("tlbr_d");

    expect_ev(1, 0, 0, 0, 6'h0c, 32'h55550000, 32'h30);
    commit(32'h30, 0, 4'b0010, 6'b000001, 32'h77770000, 0, 0, 0);
    check_pulse("brk_over_m");

    expect_ev(1, 0, 0, 0, 6'h02, 32'h9, 32'h34);
    commit(32'h34, 0, 0, 6'b011000, 32'h9, 0, 0, 0);
    check_pulse("pis_over_pme");

    expect_ev(0, 1, 0, 0, 6'h00, 32'h9, 32'h38);
    commit(32'h38, 0, 0, 0, 32'h1111, 1, 0, 1);
    check_pulse("ertn");

    expect_ev(0, 0, 0, 1, 6'h00, 32'h9, 32'h40);
    commit(32'h40, 0, 0, 0, 0, 0, 1, 0);
    check_pulse("idle");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rdy0", bus.cmt_ready, 0);
    end
    is = 12'h800; lie = 12'h800; ie = 1'b1;
    expect_ev(1, 0, 0, 0, 6'h00, 32'h9, 32'h40);
    @(negedge clk);
    check_pulse("idle_wake");
    is = '0; lie = '0; ie = 1'b0;

    is = 12'h004; lie = 12'h004; ie = 1'b1;
    expect_ev(1, 0, 0, 0, 6'h00, 32'h9, 32'h44);
    commit(32'h44, 0, 0, 0, 0, 0, 1, 0);
    check_pulse("idle_int");
    ie = 1'b0;

    expect_ev(0, 0, 1, 0, 6'h00, 32'h9, 32'h80);
    commit(32'h80, 0, 0, 0, 0, 0, 0, 1);
    check_pulse("refetch");
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_rdy", bus.cmt_ready, 0);
    quiet("rst2_pulses");
    chk("rst2_code", excode, 0);
    chk("rst2_badv", badvaddr, 0);
    chk("rst2_pc", csr_pc, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_run", bus.cmt_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
